// File: rtl/write_back_pkg.sv
// ----------------------------------------------------------------------------
// Package wb_pkg
// Shared widths, the zero-register constant and the MEM/WB pipeline record
// used by the write-back stage.
//   DATA_W     : datapath / register width
//   REG_ADDR_W : register index width
//   NUM_REGS   : architectural register count (2**REG_ADDR_W)
// ----------------------------------------------------------------------------
package wb_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] write_reg;
        logic [DATA_W-1:0]     read_data;
        logic [DATA_W-1:0]     alu_res;
    } memwb_t;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/write_back_reg_file.sv
// ----------------------------------------------------------------------------
// Module reg_file
// Architectural register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear. Register 0 always reads zero and
// ignores writes.
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low clear
//   we/waddr/wdata   write port (sampled on the rising edge)
//   raddr_a/rdata_a  read port A (combinational)
//   raddr_b/rdata_b  read port B (combinational)
// ----------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Entry 0 is never written, but the read is forced anyway so r0 stays
    // zero regardless of how the write side is driven.
    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/write_back.sv
// ----------------------------------------------------------------------------
// Module write_back
// Final pipeline stage: MEM/WB pipeline register, load/ALU result select,
// register-file commit, decode read ports and a committed-instruction counter.
// Optional feature macro: WB_BYPASS_EN -- when defined, the read ports forward
// wb_data for a matching pending write in the same cycle.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   stall, flush                hold / bubble the MEM/WB register (flush wins)
//   in_valid, in_reg_write,
//   in_mem_to_reg, in_write_reg,
//   read_data, alu_res          instruction leaving the memory-access stage
//   rs_addr/rs_data,
//   rt_addr/rt_data             decode read ports
//   wb_valid                    MEM/WB holds a live instruction
//   wb_reg_write                qualified write enable (valid, writes, dest != 0)
//   wb_write_reg, wb_data       destination index and selected value
//   retired                     committed-instruction count (wraps)
// ----------------------------------------------------------------------------
module write_back
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    input  logic [DATA_W-1:0]     read_data,
    input  logic [DATA_W-1:0]     alu_res,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic [31:0]           retired
);

    memwb_t            memwb_q;
    logic              commit_done;
    logic              commit_en;
    logic [DATA_W-1:0] rf_rs_data;
    logic [DATA_W-1:0] rf_rt_data;

    // The entry currently in MEM/WB is committed/counted on the edge where it
    // is live and not yet done. While stalled it stays put, so commit_done
    // records that it has already been processed; any newly captured entry
    // (including a flush bubble) starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memwb_q     <= '0;
            commit_done <= 1'b0;
        end else if (flush) begin
            memwb_q     <= '0;
            commit_done <= 1'b0;
        end else if (stall) begin
            commit_done <= memwb_q.valid;
        end else begin
            memwb_q.valid      <= in_valid;
            memwb_q.reg_write  <= in_reg_write;
            memwb_q.mem_to_reg <= in_mem_to_reg;
            memwb_q.write_reg  <= in_write_reg;
            memwb_q.read_data  <= read_data;
            memwb_q.alu_res    <= alu_res;
            commit_done        <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (memwb_q.valid && !commit_done) begin
            retired <= retired + 32'd1;
        end
    end

    assign wb_valid     = memwb_q.valid;
    assign wb_write_reg = memwb_q.write_reg;
    assign wb_data      = memwb_q.mem_to_reg ? memwb_q.read_data : memwb_q.alu_res;
    assign wb_reg_write = memwb_q.valid && memwb_q.reg_write
                          && !is_zero_reg(memwb_q.write_reg);
    assign commit_en    = wb_reg_write && !commit_done;

    reg_file #(
        .WIDTH  (DATA_W),
        .ADDR_W (REG_ADDR_W),
        .DEPTH  (NUM_REGS)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (commit_en),
        .waddr   (memwb_q.write_reg),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (rf_rs_data),
        .rdata_b (rf_rt_data)
    );

`ifdef WB_BYPASS_EN
    // Write-before-read: decode sees the pending value in the same cycle.
    // wb_reg_write already excludes r0, so a zero address never forwards.
    always_comb begin
        rs_data = rf_rs_data;
        rt_data = rf_rt_data;
        if (wb_reg_write && (rs_addr == memwb_q.write_reg)) begin
            rs_data = wb_data;
        end
        if (wb_reg_write && (rt_addr == memwb_q.write_reg)) begin
            rt_data = wb_data;
        end
    end
`else
    assign rs_data = rf_rs_data;
    assign rt_data = rf_rt_data;
`endif

endmodule

// File: tb/tb_write_back.sv
module tb_write_back;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [4:0]  in_write_reg;
    logic [31:0] read_data;
    logic [31:0] alu_res;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_data;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [32];
    logic [31:0] exp_retired;

    write_back dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_write_reg  (in_write_reg),
        .read_data     (read_data),
        .alu_res       (alu_res),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_data       (wb_data),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        rw;
        logic        m2r;
        logic [4:0]  wr;
        logic [31:0] rd;
        logic [31:0] alu;
        logic        exp_wbrw;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [4:0] wr, input logic [31:0] rd, input logic [31:0] alu);
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        in_write_reg  = wr;
        read_data     = rd;
        alu_res       = alu;
    endtask

    initial begin
        logic [31:0] pre;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd5,  32'h0000_0000, 32'h0000_1234, 1'b1, 32'h0000_1234};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd9,  32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0000, 32'h0000_0055, 1'b0, 32'h0000_0055};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd13, 32'h0000_0000, 32'h0000_0077, 1'b0, 32'h0000_0077};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 5'd31, 32'h1111_1111, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 5'd5,  32'hA5A5_A5A5, 32'h0000_0001, 1'b1, 32'hA5A5_A5A5};

        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_retired = '0;

        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
        rs_addr = '0;
        rt_addr = '0;

        // Reset held 3 cycles, outputs quiet throughout.
        repeat (3) tick();
        check("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("reset_wb_data", wb_data, 32'd0);
        check("reset_retired_low", retired, 32'd0);
        reset = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            rs_addr = a[4:0];
            rt_addr = 5'(31 - a);
            #1;
            check("reset_rs_data", rs_data, 32'd0);
            check("reset_rt_data", rt_data, 32'd0);
        end
        check("reset_retired", retired, 32'd0);
        check("reset_wb_valid_high", {31'd0, wb_valid}, 32'd0);

        // Table-driven single-instruction commits.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].wr, vecs[i].rd, vecs[i].alu);
            rs_addr = vecs[i].wr;
            rt_addr = vecs[i].wr;
            tick();
            drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
            #1;
`ifdef WB_BYPASS_EN
            pre = vecs[i].exp_wbrw ? vecs[i].exp_data : model[vecs[i].wr];
`else
            pre = model[vecs[i].wr];
`endif
            check("vec_wb_valid", {31'd0, wb_valid}, {31'd0, vecs[i].v});
            check("vec_wb_reg_write", {31'd0, wb_reg_write}, {31'd0, vecs[i].exp_wbrw});
            check("vec_wb_data", wb_data, vecs[i].exp_data);
            check("vec_wb_write_reg", {27'd0, wb_write_reg}, {27'd0, vecs[i].wr});
            check("vec_rs_before_commit", rs_data, pre);
            tick();
            if (vecs[i].exp_wbrw) model[vecs[i].wr] = vecs[i].exp_data;
            if (vecs[i].v) exp_retired = exp_retired + 32'd1;
            check("vec_rt_after_commit", rt_data, model[vecs[i].wr]);
            check("vec_retired", retired, exp_retired);
        end

        // Stall 4 cycles on an entry for r3: one commit, one retire.
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0000_0033);
        tick();
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h0000_0044);
        repeat (4) tick();
        rs_addr = 5'd3;
        rt_addr = 5'd4;
        #1;
        check("stall_retired_once", retired, exp_retired + 32'd1);
        check("stall_write_reg_held", {27'd0, wb_write_reg}, 32'd3);
        check("stall_wb_data_held", wb_data, 32'h0000_0033);
        check("stall_r3_written", rs_data, 32'h0000_0033);
        check("stall_r4_untouched", rt_data, 32'd0);
        stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
        tick();
        model[3] = 32'h0000_0033;
        exp_retired = exp_retired + 32'd1;
        check("stall_release_retired", retired, exp_retired);

        // Flush and stall together: bubble wins, nothing written.
        drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h0, 32'h0000_0066);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        check("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("flush_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        check("flush_wb_data", wb_data, 32'd0);
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
        tick();
        rs_addr = 5'd6;
        #1;
        check("flush_r6_zero", rs_data, 32'd0);
        check("flush_retired", retired, exp_retired);

        // Pending write to r7: bypass visibility, then reset before commit.
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h0, 32'h0000_00AA);
        rs_addr = 5'd7;
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
        #1;
`ifdef WB_BYPASS_EN
        check("bypass_r7_same_cycle", rs_data, 32'h0000_00AA);
`else
        check("nobypass_r7_old_value", rs_data, model[7]);
`endif
        reset = 1'b0;
        #1;
        check("midreset_rs", rs_data, 32'd0);
        check("midreset_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("midreset_wb_data", wb_data, 32'd0);
        check("midreset_retired", retired, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_retired = '0;
        rt_addr = 5'd5;
        #1;
        check("midreset_r7_stays_zero", rs_data, 32'd0);
        check("midreset_r5_cleared", rt_data, 32'd0);
        check("midreset_retired_after", retired, exp_retired);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
